// File: rtl/wino_output_transform.sv
// Winograd F(4,3) output stage: accumulates 6x6 product tiles over input
// channels, applies Y = A^T*M*A, saturates and emits a 4x4 tile + addresses.
// Ports: clk, reset (async, high); in_tile/in_valid/in_ready/in_last,
// in_base_addr, in_row_stride; out_tile/out_addr/out_valid/out_ready.
module wino_output_transform #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [36*PROD_W-1:0]  in_tile,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [15:0]           in_base_addr,
  input  logic [8:0]            in_row_stride,
  output logic [16*OUT_W-1:0]   out_tile,
  output logic [16*16-1:0]      out_addr,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int IW = ACC_W + 10;

  localparam logic signed [IW-1:0] MAXV =
    IW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [IW-1:0] MINV = -MAXV - IW'(1);

  typedef enum logic [1:0] {
    ACCUM,
    ROW,
    COL,
    OUT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [ACC_W-1:0] r_acc [36];
  logic                    r_first;
  logic signed [IW-1:0]    r_t   [24];
  logic [15:0]             r_base;
  logic [8:0]              r_stride;
  logic [OUT_W-1:0]        r_y   [16];
  logic [15:0]             r_addr[16];
  logic                    r_out_valid;

  logic                    w_accept;
  logic                    w_done;
  logic signed [ACC_W-1:0] w_ext [36];
  logic signed [IW-1:0]    w_t   [24];
  logic [OUT_W-1:0]        w_y   [16];
  logic [15:0]             w_off [4];
  logic [15:0]             w_addr[16];

  function automatic logic signed [IW-1:0] sx(
    input logic signed [ACC_W-1:0] a
  );
    return {{(IW-ACC_W){a[ACC_W-1]}}, a};
  endfunction

  // One row of A^T applied to a 6-vector; scaling by 2/4/8 uses shifts.
  function automatic logic signed [IW-1:0] xf(
    input logic [1:0]           r,
    input logic signed [IW-1:0] a0,
    input logic signed [IW-1:0] a1,
    input logic signed [IW-1:0] a2,
    input logic signed [IW-1:0] a3,
    input logic signed [IW-1:0] a4,
    input logic signed [IW-1:0] a5
  );
    logic signed [IW-1:0] s12, d12, s34, d34;
    logic signed [IW-1:0] res;
    s12 = a1 + a2;
    d12 = a1 - a2;
    s34 = a3 + a4;
    d34 = a3 - a4;
    case (r)
      2'd0:    res = a0 + s12 + s34;
      2'd1:    res = d12 + (d34 <<< 1);
      2'd2:    res = s12 + (s34 <<< 2);
      default: res = d12 + (d34 <<< 3) + a5;
    endcase
    return res;
  endfunction

  function automatic logic [OUT_W-1:0] sat(
    input logic signed [IW-1:0] v
  );
    logic [OUT_W-1:0] res;
    if (v > MAXV)
      res = MAXV[OUT_W-1:0];
    else if (v < MINV)
      res = MINV[OUT_W-1:0];
    else
      res = v[OUT_W-1:0];
    return res;
  endfunction

  always_comb begin
    in_ready = (r_state == ACCUM);
    w_accept = in_valid && in_ready;
    w_done   = (r_state == OUT) && out_ready;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ACCUM: if (w_accept && in_last) w_next = ROW;
      ROW:   w_next = COL;
      COL:   w_next = OUT;
      OUT:   if (out_ready) w_next = ACCUM;
      default: w_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= ACCUM;
    else
      r_state <= w_next;
  end

  always_comb begin
    for (int i = 0; i < 36; i++) begin
      w_ext[i] = {{(ACC_W-PROD_W){in_tile[i*PROD_W+PROD_W-1]}},
                  in_tile[i*PROD_W +: PROD_W]};
    end
  end

  // Column pass: T = A^T * acc, one A^T row per T row.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 6; c++) begin
        w_t[6*r+c] = xf(2'(r),
                        sx(r_acc[c]),    sx(r_acc[6+c]),
                        sx(r_acc[12+c]), sx(r_acc[18+c]),
                        sx(r_acc[24+c]), sx(r_acc[30+c]));
      end
    end
  end

  // Row pass: Y[r][c] = sum_k T[r][k] * A^T[c][k].
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_y[4*r+c] = sat(xf(2'(c),
                            r_t[6*r],   r_t[6*r+1],
                            r_t[6*r+2], r_t[6*r+3],
                            r_t[6*r+4], r_t[6*r+5]));
      end
    end
  end

  always_comb begin
    w_off[0] = 16'd0;
    w_off[1] = {7'd0, r_stride};
    w_off[2] = {6'd0, r_stride, 1'b0};
    w_off[3] = w_off[1] + w_off[2];
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_addr[4*r+c] = r_base + w_off[r] + 16'(c);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 36; i++)
        r_acc[i] <= '0;
      r_first <= 1'b1;
    end else begin
      if (w_accept) begin
        for (int i = 0; i < 36; i++)
          r_acc[i] <= r_first ? w_ext[i] : r_acc[i] + w_ext[i];
        r_first <= 1'b0;
      end else if (w_done) begin
        r_first <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base   <= '0;
      r_stride <= '0;
    end else if (w_accept && in_last) begin
      r_base   <= in_base_addr;
      r_stride <= in_row_stride;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 24; i++)
        r_t[i] <= '0;
    end else if (r_state == ROW) begin
      for (int i = 0; i < 24; i++)
        r_t[i] <= w_t[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        r_y[i]    <= '0;
        r_addr[i] <= '0;
      end
      r_out_valid <= 1'b0;
    end else if (r_state == COL) begin
      for (int i = 0; i < 16; i++) begin
        r_y[i]    <= w_y[i];
        r_addr[i] <= w_addr[i];
      end
      r_out_valid <= 1'b1;
    end else if (w_done) begin
      r_out_valid <= 1'b0;
    end
  end

  always_comb begin
    out_tile  = '0;
    out_addr  = '0;
    out_valid = r_out_valid;
    for (int i = 0; i < 16; i++) begin
      out_tile[i*OUT_W +: OUT_W] = r_y[i];
      out_addr[i*16 +: 16]       = r_addr[i];
    end
  end

endmodule

// File: tb/tb_wino_output_transform.sv
// Bench for wino_output_transform: table vectors, scoreboard model,
// backpressure, accumulator clear and async reset sequences.
module tb_wino_output_transform;

  logic          clk = 1'b0;
  logic          reset;
  logic [575:0]  in_tile;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [15:0]   in_base_addr;
  logic [8:0]    in_row_stride;
  logic [191:0]  out_tile;
  logic [255:0]  out_addr;
  logic          out_valid;
  logic          out_ready;

  wino_output_transform dut (
    .clk          (clk),
    .reset        (reset),
    .in_tile      (in_tile),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_last      (in_last),
    .in_base_addr (in_base_addr),
    .in_row_stride(in_row_stride),
    .out_tile     (out_tile),
    .out_addr     (out_addr),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    longint     y[16];
    logic [15:0] a[16];
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          nb;
    int          val;
    logic [15:0] base;
    logic [8:0]  stride;
    int          e0;
    int          e10;
    int          e15;
    int          ea15;
  } vec_t;

  int at[4][6] = '{'{1, 1,  1, 1,  1, 0},
                   '{0, 1, -1, 2, -2, 0},
                   '{0, 1,  1, 4,  4, 0},
                   '{0, 1, -1, 8, -8, 1}};

  longint m_acc[36];
  bit     m_first = 1'b1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint gy(input int i);
    logic signed [11:0] s;
    s = out_tile[i*12 +: 12];
    return longint'(s);
  endfunction

  function automatic longint wrap24(input longint v);
    longint m;
    m = v & 64'hFFFFFF;
    if (m >= 64'sh800000) m = m - 64'sh1000000;
    return m;
  endfunction

  task automatic push_expected(input logic [15:0] base,
                               input logic [8:0] stride);
    exp_t   e;
    longint t[4][6];
    longint y;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 6; c++) begin
        t[r][c] = 0;
        for (int k = 0; k < 6; k++)
          t[r][c] += at[r][k] * m_acc[k*6+c];
      end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        y = 0;
        for (int k = 0; k < 6; k++)
          y += t[r][k] * at[c][k];
        if (y > 2047) y = 2047;
        if (y < -2048) y = -2048;
        e.y[4*r+c] = y;
        e.a[4*r+c] = 16'((int'(base) + r * int'(stride) + c) & 16'hFFFF);
      end
    sb.push_back(e);
  endtask

  task automatic send(input int v[36], input bit last,
                      input logic [15:0] base, input logic [8:0] stride);
    for (int i = 0; i < 36; i++)
      in_tile[i*16 +: 16] = 16'(v[i]);
    in_valid      = 1'b1;
    in_last       = last;
    in_base_addr  = base;
    in_row_stride = stride;
    chk("in_ready_accum", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < 36; i++)
      m_acc[i] = m_first ? longint'(v[i]) : wrap24(m_acc[i] + v[i]);
    m_first = 1'b0;
    if (last) begin
      push_expected(base, stride);
      m_first = 1'b1;
    end
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!out_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL out_valid_timeout: got 0 expected 1");
    end
  endtask

  task automatic cmp_exp(input exp_t e, input string tag);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s_y%0d", tag, i), gy(i), e.y[i]);
      chk($sformatf("%s_a%0d", tag, i),
          longint'(out_addr[i*16 +: 16]), longint'(e.a[i]));
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_sb_empty: got 0 expected 1", tag);
    end else begin
      e = sb.pop_front();
      cmp_exp(e, tag);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hs_out_valid", out_valid, 0);
    chk("hs_in_ready", in_ready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[5];
    int   v[36];
    int   cyc;
    int   nb;
    logic [15:0] b;
    logic [8:0]  s;

    vt[0] = '{1,    1, 16'd100,    9'd64,   25,   100,    1, 295};
    vt[1] = '{3,    1, 16'd0,      9'd0,    75,   300,    3, 3};
    vt[2] = '{1,  100, 16'hFFF0,   9'd16, 2047,  2047,  100, 16'h0023};
    vt[3] = '{1, -100, 16'd5,      9'd1, -2048, -2048, -100, 11};
    vt[4] = '{2,    2, 16'd0,      9'd300, 100,   400,    4, 903};

    reset         = 1'b1;
    in_tile       = '0;
    in_valid      = 1'b0;
    in_last       = 1'b0;
    in_base_addr  = '0;
    in_row_stride = '0;
    out_ready     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_tile_zero", longint'(out_tile == '0), 1);
    chk("rst_addr_zero", longint'(out_addr == '0), 1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 36; i++) v[i] = vt[k].val;
      for (int j = 0; j < vt[k].nb; j++)
        send(v, j == vt[k].nb - 1, vt[k].base, vt[k].stride);
      chk($sformatf("v%0d_in_ready_row", k), in_ready, 0);
      wait_out(cyc);
      chk($sformatf("v%0d_latency", k), cyc, 2);
      chk($sformatf("v%0d_busy", k), in_ready, 0);
      chk($sformatf("v%0d_y0", k), gy(0), vt[k].e0);
      chk($sformatf("v%0d_y10", k), gy(10), vt[k].e10);
      chk($sformatf("v%0d_y15", k), gy(15), vt[k].e15);
      chk($sformatf("v%0d_a15", k),
          longint'(out_addr[15*16 +: 16]), vt[k].ea15);
      check_out($sformatf("v%0d", k));
      handshake();
    end

    for (int k = 0; k < 4; k++) begin
      nb = $urandom_range(1, 4);
      b  = 16'($urandom);
      s  = 9'($urandom);
      for (int j = 0; j < nb; j++) begin
        for (int i = 0; i < 36; i++)
          v[i] = int'($urandom_range(0, 8000)) - 4000;
        send(v, j == nb - 1, b, s);
      end
      wait_out(cyc);
      chk($sformatf("r%0d_latency", k), cyc, 2);
      check_out($sformatf("r%0d", k));
      handshake();
    end

    for (int i = 0; i < 36; i++) v[i] = 2;
    send(v, 1'b1, 16'd10, 9'd20);
    wait_out(cyc);
    for (int i = 0; i < 16; i++)
      in_tile[i*16 +: 16] = 16'd50;
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_in_ready", c), in_ready, 0);
      chk($sformatf("bp%0d_out_valid", c), out_valid, 1);
      cmp_exp(sb[0], $sformatf("bp%0d", c));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_out("bp_final");
    handshake();

    for (int i = 0; i < 36; i++) v[i] = 0;
    v[0] = 7;
    send(v, 1'b1, 16'd0, 9'd4);
    wait_out(cyc);
    chk("clr_y0", gy(0), 7);
    chk("clr_y5", gy(5), 0);
    check_out("clr");
    handshake();

    for (int i = 0; i < 36; i++) v[i] = 1;
    send(v, 1'b1, 16'd100, 9'd64);
    wait_out(cyc);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_tile_zero", longint'(out_tile == '0), 1);
    chk("arst_addr_zero", longint'(out_addr == '0), 1);
    void'(sb.pop_front());
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 36; i++) v[i] = 3;
    send(v, 1'b1, 16'd1, 9'd1);
    wait_out(cyc);
    chk("post_rst_latency", cyc, 2);
    check_out("post_rst");
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
